div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider controller/datapath serving the EX stage for DIV and DIVU.
- EX raises a start request with latched operands and stalls the pipeline until the unit reports ready.
- The result is written to HI/LO through EX's existing hi_o/lo_o/whilo_o path: HI = remainder, LO = quotient.
- Also supports annulment, so a divide in a branch delay or flushed slot can be dropped.

---
 rtl/div_unit_pkg.sv | 16 +
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared state codes and handshake encodings for the multi-cycle divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BYZERO  = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result packed as {remainder, quotient} and held while EX keeps start_i high.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    div_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2*DATA_W:0]      work_reg, work_next;
    logic [DATA_W-1:0]      divisor_reg, divisor_next;
    logic                   neg_quot_reg, neg_quot_next;
    logic                   neg_rem_reg, neg_rem_next;
    logic [2*DATA_W-1:0]    result_reg, result_next;

    logic [2*DATA_W:0]      step_work;
    logic [DATA_W-1:0]      step_quot, step_rem;
    logic [DATA_W-1:0]      mag_dividend, mag_divisor;

    // Shift left, trial-subtract the divisor from the upper half; keep the
    // difference and shift in a 1 only when it did not go negative.
    function automatic logic [2*DATA_W:0] div_step(input logic [2*DATA_W:0] work,
                                                    input logic [DATA_W-1:0] dvs);
        logic [2*DATA_W:0]  sh;
        logic [DATA_W+1:0]  trial;
        sh    = work << 1;
        trial = {1'b0, sh[2*DATA_W:DATA_W]} - {2'b00, dvs};
        if (!trial[DATA_W+1])
            div_step = {trial[DATA_W:0], sh[DATA_W-1:1], 1'b1};
        else
            div_step = sh;
    endfunction

    assign step_work    = div_step(work_reg, divisor_reg);
    assign step_quot    = neg_quot_reg ? -step_work[DATA_W-1:0] : step_work[DATA_W-1:0];
    assign step_rem     = neg_rem_reg ? -step_work[2*DATA_W-1:DATA_W]
                                      : step_work[2*DATA_W-1:DATA_W];
    assign mag_dividend = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag_divisor  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        work_next     = work_reg;
        divisor_next  = divisor_reg;
        neg_quot_next = neg_quot_reg;
        neg_rem_next  = neg_rem_reg;
        result_next   = result_reg;
        case (state_reg)
            DIV_FREE: begin
                result_next = '0;
                if (start_i == DIV_START && !annul_i) begin
                    work_next     = {{(DATA_W+1){1'b0}}, mag_dividend};
                    divisor_next  = mag_divisor;
                    neg_quot_next = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    neg_rem_next  = signed_div_i && opdata1_i[DATA_W-1];
                    cnt_next      = '0;
                    state_next    = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                result_next = '0;
                state_next  = DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    result_next = '0;
                    state_next  = DIV_FREE;
                end else begin
                    work_next = step_work;
                    cnt_next  = cnt_reg + 1'b1;
                    // Final iteration lands the corrected result on the same edge.
                    if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                        result_next = {step_rem, step_quot};
                        state_next  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP || annul_i) begin
                    result_next = '0;
                    state_next  = DIV_FREE;
                end
            end
            default: begin
                result_next = '0;
                state_next  = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= DIV_FREE;
            cnt_reg      <= '0;
            work_reg     <= '0;
            divisor_reg  <= '0;
            neg_quot_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            result_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            work_reg     <= work_next;
            divisor_reg  <= divisor_next;
            neg_quot_reg <= neg_quot_next;
            neg_rem_reg  <= neg_rem_next;
            result_reg   <= result_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = (state_reg == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign busy_o   = (state_reg == DIV_BYZERO) || (state_reg == DIV_ON);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results are queued at issue and
// popped when ready_o is observed.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    logic [63:0] sb[$];

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int q, r;
        if (b == 32'h0) return 64'h0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one divide, wait (bounded) for ready, check latency and result,
    // optionally hold start with scrambled operands, then release.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat, input int hold);
        int edges;
        bit got;
        logic [63:0] want;
        @(negedge clk);
        signed_div = sgn; opdata1 = a; opdata2 = b; start = 1'b1;
        sb.push_back(exp);
        edges = 0; got = 0;
        while (edges < 100 && !got) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1 && b == 32'h0) check("byzero_busy", {63'h0, busy}, 64'h1);
            if (ready) got = 1;
        end
        check("latency", 64'(edges), 64'(exp_lat));
        want = sb.pop_front();
        check("result", result, want);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            opdata1 = ~a; opdata2 = b + 32'd5; signed_div = ~sgn;
            @(posedge clk); #1;
            check("hold_ready", {63'h0, ready}, 64'h1);
            check("hold_result", result, want);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("release_ready", {63'h0, ready}, 64'h0);
        check("release_result", result, 64'h0);
        check("release_busy", {63'h0, busy}, 64'h0);
        $display("txn sgn=%0d a=%h b=%h result=%h latency=%0d", sgn, a, b, want, edges);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs;
        int          edges;
        signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;
        rst = 1'b0;
        #2;
        check("reset_result", result, 64'h0);
        check("reset_ready", {63'h0, ready}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        @(negedge clk); rst = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        run_div(1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0);
        run_div(1'b0, 32'd5, 32'd0, 64'h0, 2, 0);

        // Annul on the 10th RUN cycle
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        check("annul_busy_before", {63'h0, busy}, 64'h1);
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        check("annul_busy", {63'h0, busy}, 64'h0);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) edges++;
        end
        check("annul_no_ready", 64'(edges), 64'h0);
        $display("txn annulled 1000/3 ready_seen=%0d", edges);
        run_div(1'b0, 32'd50, 32'd5, {32'h0, 32'hA}, 33, 0);

        // Asynchronous reset during RUN
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'h1234_5678; opdata2 = 32'd3; start = 1'b1;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        check("pre_reset_busy", {63'h0, busy}, 64'h1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        check("async_rst_ready", {63'h0, ready}, 64'h0);
        check("async_rst_result", result, 64'h0);
        start = 1'b0;
        @(negedge clk); rst = 1'b1;
        $display("txn reset during RUN");
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 0);

        // Asynchronous reset while a result is held
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd9; opdata2 = 32'd2; start = 1'b1;
        edges = 0;
        while (edges < 100 && !ready) begin
            @(posedge clk); #1; edges++;
        end
        check("done_result", result, {32'h1, 32'h4});
        #2 rst = 1'b0;
        #1;
        check("done_rst_result", result, 64'h0);
        check("done_rst_ready", {63'h0, ready}, 64'h0);
        start = 1'b0;
        @(negedge clk); rst = 1'b1;
        $display("txn reset during DONE");

        // Hold start past ready with operands changed after capture
        run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 5);

        // start and annul together in IDLE: nothing captured
        @(negedge clk);
        opdata1 = 32'd77; opdata2 = 32'd7; start = 1'b1; annul = 1'b1;
        edges = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy || ready) edges++;
        end
        check("start_annul_idle", 64'(edges), 64'h0);
        @(negedge clk); start = 1'b0; annul = 1'b0;
        $display("txn start+annul in IDLE activity=%0d", edges);

        for (int k = 0; k < 6; k++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'h0) rb = 32'd13;
            run_div(rs, ra, rb, ref_div(rs, ra, rb), 33, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
